// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, register count and destination decode.
// Used by the decode stage, the ALU and the later pipeline stages.
package cpu_pkg;

  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic              has_dest;
    logic [REG_AW-1:0] addr;
  } dest_t;

  // Register 0 as a destination is folded into "no destination".
  function automatic dest_t dest_of(input logic [XLEN-1:0] instr);
    dest_t d;
    logic  unused_fields;
    unused_fields = ^{instr[25:21], instr[10:0]};
    d.has_dest = 1'b0;
    d.addr     = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.has_dest = 1'b1;
        d.addr     = instr[15:11];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        d.has_dest = 1'b1;
        d.addr     = instr[20:16];
      end
      default: begin
        d.has_dest = 1'b0;
        d.addr     = '0;
      end
    endcase
    if (d.addr == '0) d.has_dest = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes; all registers clear on reset.
module regfile #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage with a per-register pending scoreboard and one output slot.
// Define DECODE_WB_FWD_EN to let a same-cycle writeback resolve source hazards and bypass its data.
module decode_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_regA,
  output logic [XLEN-1:0] out_regB,
  input  logic            wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_instr_q, out_regA_q, out_regB_q;
  logic [NREG-1:0]   pending_q, pending_d;

  logic [REG_AW-1:0] rs, rt;
  logic [XLEN-1:0]   rf_a, rf_b, src_a, src_b;
  dest_t             in_dst, held_dst;
  logic              wb_fire, fwd_a, fwd_b;
  logic              haz_a, haz_b, haz_waw, hazard, accept;

  assign rs       = in_instr[25:21];
  assign rt       = in_instr[20:16];
  assign in_dst   = dest_of(in_instr);
  assign held_dst = dest_of(out_instr_q);
  assign wb_fire  = wb_en && (wb_addr != '0);

  regfile #(
    .NREG  (NREG),
    .DATA_W(XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr_a(rs),
    .rdata_a(rf_a),
    .raddr_b(rt),
    .rdata_b(rf_b),
    .we     (wb_fire),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

`ifdef DECODE_WB_FWD_EN
  assign fwd_a = wb_fire && (wb_addr == rs);
  assign fwd_b = wb_fire && (wb_addr == rt);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign src_a = fwd_a ? wb_data : rf_a;
  assign src_b = fwd_b ? wb_data : rf_b;

  // Register 0 never carries a pending bit, so it can never stall a source.
  assign haz_a   = (rs != '0) && pending_q[rs] && !fwd_a;
  assign haz_b   = (rt != '0) && pending_q[rt] && !fwd_b;
  assign haz_waw = in_dst.has_dest && pending_q[in_dst.addr];
  assign hazard  = haz_a || haz_b || haz_waw;

  assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Later updates take priority: a new destination claim overrides a same-cycle clear.
  always_comb begin
    pending_d = pending_q;
    if (wb_fire) pending_d[wb_addr] = 1'b0;
    if (flush && out_valid_q && held_dst.has_dest) pending_d[held_dst.addr] = 1'b0;
    if (accept && in_dst.has_dest) pending_d[in_dst.addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (flush)     out_valid_d = 1'b0;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // Output slot and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_regA_q  <= '0;
      out_regB_q  <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
      if (accept) begin
        out_instr_q <= in_instr;
        out_regA_q  <= src_a;
        out_regB_q  <= src_b;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_regA  = out_regA_q;
  assign out_regB  = out_regB_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode / register-read stage directly upstream of the ALU. Accepts one 32-bit MIPS instruction per handshake, reads `rs`/`rt` from an internal 32×32 register file, and presents `instruction`/`regA`/`regB` to the ALU through one registered output slot. A one-bit-per-register scoreboard stalls read-after-write and write-after-write hazards against writebacks that are still in flight.

## Interface
- `NREG`, 32: register count; register 0 is hardwired to zero.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_instr`  in  32  instruction word.
- `in_ready`  out  1  stage accepts `in_instr` this cycle.
- `out_valid`  out  1  output slot holds a decoded instruction.
- `out_ready`  in  1  ALU side consumes the slot.
- `out_instr`  out  32  instruction to the ALU `instruction` input.
- `out_regA`  out  32  `rs` value for the ALU `regA` input.
- `out_regB`  out  32  `rt` value for the ALU `regB` input.
- `wb_en`  in  1  writeback strobe.
- `wb_addr`  in  5  writeback register.
- `wb_data`  in  32  writeback value.
- `flush`  in  1  discards the output slot.

## Operation
- Destination decode:
  - R-type (opcode 0): `rd`.
  - addi, addiu, slti, sltiu, andi, ori, xori, lw: `rt`.
  - beq, bne, sw, unknown opcodes: no destination.
  - A destination of register 0 counts as no destination.
- Sources: `rs` and `rt` are always read. A source of register 0 never causes a hazard.
- Hazard: asserted if a source's pending bit is set, or if the destination's pending bit is set (WAW).
- `in_ready` = `!hazard && !flush && (!out_valid || out_ready)`.
- Accept (`in_valid && in_ready`):
  - Load `out_instr`, `out_regA` and `out_regB`.
  - Set `out_valid`.
  - Set the destination's pending bit.
- Slot consumed without a new accept: `out_valid` clears and the data outputs hold their values.
- Writeback (`wb_en`, `wb_addr` ≠ 0): write the register file and clear that register's pending bit.
  - If the same cycle sets the same bit, the set wins.
  - A write to register 0 is ignored.
- Flush:
  - `out_valid` clears.
  - The held instruction's destination pending bit clears.
  - No accept occurs that cycle.
- Reset values:
  - `out_valid` = 0.
  - `out_instr`, `out_regA`, `out_regB` = 0.
  - All registers = 0.
  - All pending bits = 0.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when there is no hazard and `out_ready` is high.
- `out_*` stay stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready`, `flush`, the scoreboard, and `wb_*` (when forwarding is enabled).
- Back-to-back dependent instructions stall until the producer's writeback.
- `rst` asserted mid-stall or mid-hold returns everything to the reset values immediately; any in-flight writeback is lost.

## Configuration
- `DECODE_WB_FWD_EN` defined:
  - A same-cycle writeback matching a pending source counts as resolved.
  - `wb_data` is bypassed into `out_regA`/`out_regB`.
  - The instruction is accepted in the writeback cycle.
- `DECODE_WB_FWD_EN` undefined:
  - The hazard persists in the writeback cycle.
  - The instruction is accepted one cycle later, reading the register file.
  - Dependent-instruction latency is +1 cycle.

## Structure
- Shared package `cpu_pkg`:
  - Opcode and funct localparams.
  - `NREG`.
  - Function `dest_of(instr)` returning {has_dest, addr}.
  - Shared with the ALU and the later stages.
- Sub-module `regfile`:
  - 2 asynchronous read ports, 1 synchronous write port, register 0 reads as zero, async reset.
  - Scoreboard and bypass stay in `decode_stage`.

## Test plan
- Reset, then issue `addi $1,$0,5` (0x20010005) → next cycle `out_valid`=1, `out_instr`=0x20010005, `out_regA`=0; pending[1]=1.
- `addi $1` issued, then `add $2,$1,$1` → `in_ready`=0 until `wb_en`,`wb_addr`=1,`wb_data`=5:
  - with `DECODE_WB_FWD_EN`: accepted that cycle; `out_regA`=`out_regB`=5.
  - without it: accepted one cycle later.
- Hold `out_ready`=0 for 3 cycles while `in_valid`=1 → `out_*` unchanged and `in_ready`=0; `out_ready`=1 → next instruction loads the following cycle.
- `sw $3,0($4)` (0xAC830000) → no pending bit set; a following `lw $5,4($4)` is issued without stall.
- `flush` while holding `addi $6,...` → `out_valid`=0 and pending[6]=0; a dependent reader of `$6` is accepted next cycle.
- `wb_en`, `wb_addr`=0, `wb_data`=0xFFFFFFFF, then `add $7,$0,$0` → `out_regA`=`out_regB`=0.
